dma_sched: RTL and testbench

DMA_SCHED -- requirements
Module: dma_sched

---
 rtl/dma_sched_if.sv | 43 ++++
 rtl/dma_sched.sv | 119 +++++++++++
 tb/tb_dma_sched.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_sched_if.sv
`default_nettype none
//============================================================================
// Module   : dma_sched_if
// Bundles the requester descriptor ports and the DMA engine handshake.
// Revision : 1.0
//============================================================================
interface dma_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int C_ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*64-1:0] req_src;
    logic [NUM_REQ*64-1:0] req_dst;
    logic [NUM_REQ*32-1:0] req_len;

    logic                  dma_start;
    logic [63:0]           dma_src;
    logic [63:0]           dma_dst;
    logic [31:0]           dma_len;
    logic                  dma_done;

    logic                  cpl_valid;
    logic [C_ID_W-1:0]     cpl_id;
    logic                  cpl_err;
    logic                  busy;

    // Scheduler side
    modport slave (
        input  req_valid, req_src, req_dst, req_len, dma_done,
        output req_ready, dma_start, dma_src, dma_dst, dma_len,
               cpl_valid, cpl_id, cpl_err, busy
    );

    // Requesters / engine side
    modport master (
        output req_valid, req_src, req_dst, req_len, dma_done,
        input  req_ready, dma_start, dma_src, dma_dst, dma_len,
               cpl_valid, cpl_id, cpl_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dma_sched.sv
`default_nettype none
//============================================================================
// Module   : dma_sched
// Round-robin descriptor scheduler driving a single-outstanding DMA engine.
// Revision : 1.0
//============================================================================
module dma_sched #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    dma_sched_if.slave  bus
);
    localparam int C_ID_W  = $clog2(NUM_REQ);
    localparam int C_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT - 1);
    localparam logic [C_ID_W-1:0]  C_LAST_RST = C_ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CPL   = 2'd3
    } state_t;

    state_t              r_state;
    logic [C_ID_W-1:0]   r_last_grant;
    logic [C_ID_W-1:0]   r_cur_id;
    logic [C_TMR_W-1:0]  r_timer;

    logic                w_grant_vld;
    logic [C_ID_W-1:0]   w_grant;

    // Walk from farthest to nearest so the requester closest after last_grant wins.
    always_comb begin
        logic [C_ID_W-1:0] idx;
        idx         = '0;
        w_grant_vld = 1'b0;
        w_grant     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = C_ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = idx;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (r_state == S_IDLE && w_grant_vld) begin
            bus.req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_last_grant  <= C_LAST_RST;
            r_cur_id      <= '0;
            r_timer       <= '0;
            bus.dma_start <= 1'b0;
            bus.dma_src   <= '0;
            bus.dma_dst   <= '0;
            bus.dma_len   <= '0;
            bus.cpl_valid <= 1'b0;
            bus.cpl_id    <= '0;
            bus.cpl_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.dma_start <= 1'b0;
            bus.cpl_valid <= 1'b0;
            bus.cpl_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        bus.dma_src   <= bus.req_src[int'(w_grant)*64 +: 64];
                        bus.dma_dst   <= bus.req_dst[int'(w_grant)*64 +: 64];
                        bus.dma_len   <= bus.req_len[int'(w_grant)*32 +: 32];
                        r_cur_id      <= w_grant;
                        bus.dma_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // Completion beats the timeout when both land together.
                    if (bus.dma_done) begin
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_id    <= r_cur_id;
                        bus.cpl_err   <= 1'b0;
                        r_state       <= S_CPL;
                    end else if (r_timer == C_TMR_LAST) begin
                        bus.cpl_valid <= 1'b1;
                        bus.cpl_id    <= r_cur_id;
                        bus.cpl_err   <= 1'b1;
                        r_state       <= S_CPL;
                    end
                end
                S_CPL: begin
                    r_last_grant <= r_cur_id;
                    bus.busy     <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dma_sched.sv
`default_nettype none
//============================================================================
// Module   : tb_dma_sched
// Scoreboard bench for the round-robin DMA descriptor scheduler.
// Revision : 1.0
//============================================================================
module tb_dma_sched;
    localparam int NR = 4;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_sched_if #(.NUM_REQ(NR)) bus();

    dma_sched #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          id;
        bit          err;
        logic [63:0] src;
        logic [63:0] dst;
        logic [31:0] len;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] d_src[NR];
    logic [63:0] d_dst[NR];
    logic [31:0] d_len[NR];

    int n_checks  = 0;
    int n_fail    = 0;
    int cpl_count = 0;

    always @(negedge clk) if (bus.cpl_valid === 1'b1) cpl_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.dma_done  = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_desc(input int i, input logic [63:0] s, input logic [63:0] d,
                            input logic [31:0] l);
        d_src[i] = s;
        d_dst[i] = d;
        d_len[i] = l;
        bus.req_src[64*i +: 64] = s;
        bus.req_dst[64*i +: 64] = d;
        bus.req_len[32*i +: 32] = l;
    endtask

    function automatic exp_t mk(input int i, input bit err);
        exp_t e;
        e.id  = i;
        e.err = err;
        e.src = d_src[i];
        e.dst = d_dst[i];
        e.len = d_len[i];
        return e;
    endfunction

    task automatic wait_start(output int n);
        n = 0;
        while (bus.dma_start !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) n = -1;
    endtask

    task automatic wait_cpl(output int n);
        n = 0;
        while (bus.cpl_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) n = -1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.dma_done  = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        n_checks++;
        if (bus.dma_start !== 1'b0 || bus.cpl_valid !== 1'b0 || bus.cpl_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got start=%b cpl=%b err=%b expected 0/0/0",
                               bus.dma_start, bus.cpl_valid, bus.cpl_err);
        end
        n_checks++;
        if ({bus.dma_src, bus.dma_dst, bus.dma_len} !== 160'd0) begin
            n_fail++; $display("FAIL reset_regs: got src=%h dst=%h len=%h expected 0",
                               bus.dma_src, bus.dma_dst, bus.dma_len);
        end
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int   n;
        exp_t e;
        do_reset();
        set_desc(0, 64'h1000, 64'h2000, 32'd3);
        bus.req_valid = 4'b0001;
        sb.push_back(mk(0, 1'b0));
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready);
        end
        wait_start(n);
        bus.req_valid = '0;
        n_checks++;
        if (n !== 1) begin
            n_fail++; $display("FAIL single_start_latency: got %0d expected 1", n);
        end
        n_checks++;
        if (bus.dma_src !== sb[0].src || bus.dma_dst !== sb[0].dst || bus.dma_len !== sb[0].len) begin
            n_fail++; $display("FAIL single_issue: got %h/%h/%0d expected %h/%h/%0d",
                               bus.dma_src, bus.dma_dst, bus.dma_len, sb[0].src, sb[0].dst, sb[0].len);
        end
        tick();
        n_checks++;
        if (bus.dma_start !== 1'b0) begin
            n_fail++; $display("FAIL single_start_width: got %b expected 0", bus.dma_start);
        end
        repeat (4) tick();
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        n_checks++;
        if (bus.cpl_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_cpl_valid: got %b expected 1", bus.cpl_valid);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (bus.cpl_id !== 2'(e.id) || bus.cpl_err !== e.err) begin
                n_fail++; $display("FAIL single_cpl_fields: got id=%0d err=%b expected id=%0d err=%b",
                                   bus.cpl_id, bus.cpl_err, e.id, e.err);
            end
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.cpl_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got busy=%b cpl=%b expected 0/0", bus.busy, bus.cpl_valid);
        end
    endtask

    task automatic test_fairness();
        int   n;
        int   base;
        int   last;
        int   exp_id;
        exp_t e;
        do_reset();
        for (int i = 0; i < NR; i++)
            set_desc(i, 64'h1000_0000 * (i + 1) + 64'h40, 64'h8000_0000 + 64'h100 * i, 32'd16 + i);
        base = cpl_count;
        last = NR - 1;
        bus.req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            exp_id = (last + 1) % NR;
            sb.push_back(mk(exp_id, 1'b0));
            wait_start(n);
            n_checks++;
            if (n !== ((t == 0) ? 1 : 2)) begin
                n_fail++; $display("FAIL fair_start_latency[%0d]: got %0d expected %0d", t, n, (t == 0) ? 1 : 2);
            end
            n_checks++;
            if (bus.dma_src !== sb[0].src || bus.dma_len !== sb[0].len) begin
                n_fail++; $display("FAIL fair_issue[%0d]: got %h/%0d expected %h/%0d",
                                   t, bus.dma_src, bus.dma_len, sb[0].src, sb[0].len);
            end
            tick();
            tick();
            bus.dma_done = 1'b1;
            tick();
            bus.dma_done = 1'b0;
            if (t == 7) bus.req_valid = '0;
            n_checks++;
            if (bus.cpl_valid !== 1'b1) begin
                n_fail++; $display("FAIL fair_cpl_valid[%0d]: got %b expected 1", t, bus.cpl_valid);
                sb.delete();
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (bus.cpl_id !== 2'(e.id) || bus.cpl_err !== e.err) begin
                    n_fail++; $display("FAIL fair_order[%0d]: got id=%0d err=%b expected id=%0d err=%b",
                                       t, bus.cpl_id, bus.cpl_err, e.id, e.err);
                end
            end
            last = exp_id;
        end
        repeat (3) tick();
        n_checks++;
        if (cpl_count - base !== 8 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL fair_cpl_count: got %0d busy=%b expected 8 busy=0", cpl_count - base, bus.busy);
        end
    endtask

    task automatic test_timeout();
        int   n;
        int   m;
        exp_t e;
        do_reset();
        set_desc(0, 64'hA000, 64'hB000, 32'd7);
        bus.req_valid = 4'b0001;
        sb.push_back(mk(0, 1'b1));
        wait_start(n);
        bus.req_valid = '0;
        wait_cpl(m);
        n_checks++;
        if (m !== 17) begin
            n_fail++; $display("FAIL timeout_latency: got %0d expected 17", m);
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.cpl_valid !== 1'b1 || bus.cpl_err !== e.err || bus.cpl_id !== 2'(e.id)) begin
            n_fail++; $display("FAIL timeout_cpl: got valid=%b err=%b id=%0d expected 1/%b/%0d",
                               bus.cpl_valid, bus.cpl_err, bus.cpl_id, e.err, e.id);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_tie();
        int   n;
        exp_t e;
        do_reset();
        set_desc(2, 64'hC000, 64'hD000, 32'd9);
        bus.req_valid = 4'b0100;
        sb.push_back(mk(2, 1'b0));
        wait_start(n);
        bus.req_valid = '0;
        repeat (16) tick();
        n_checks++;
        if (bus.cpl_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL tie_pre: got cpl=%b busy=%b expected 0/1", bus.cpl_valid, bus.busy);
        end
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (bus.cpl_valid !== 1'b1 || bus.cpl_err !== e.err || bus.cpl_id !== 2'(e.id)) begin
            n_fail++; $display("FAIL tie_cpl: got valid=%b err=%b id=%0d expected 1/%b/%0d",
                               bus.cpl_valid, bus.cpl_err, bus.cpl_id, e.err, e.id);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n;
        int base;
        do_reset();
        set_desc(1, 64'h5000, 64'h6000, 32'd4);
        bus.req_valid = 4'b0010;
        wait_start(n);
        bus.req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.dma_start !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: got busy=%b start=%b expected 0/0", bus.busy, bus.dma_start);
        end
        base = cpl_count;
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (cpl_count !== base || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_late_done: got cpls=%0d busy=%b expected 0/0", cpl_count - base, bus.busy);
        end
        bus.req_valid = 4'b1111;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_first_grant: got %b expected 0001", bus.req_ready);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_stray_done();
        int base;
        do_reset();
        base = cpl_count;
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (cpl_count !== base || bus.busy !== 1'b0 || bus.dma_start !== 1'b0) begin
            n_fail++; $display("FAIL stray_done: got cpls=%0d busy=%b start=%b expected 0/0/0",
                               cpl_count - base, bus.busy, bus.dma_start);
        end
        bus.req_valid = 4'b0001;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL stray_ready: got %b expected 0001", bus.req_ready);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_drop_zero_len();
        int   n;
        exp_t e;
        do_reset();
        set_desc(1, 64'h1111, 64'h2222, 32'd5);
        set_desc(2, 64'h3333, 64'h4444, 32'd0);
        bus.req_valid = 4'b0110;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL drop_ready_pre: got %b expected 0010", bus.req_ready);
        end
        bus.req_valid = 4'b0100;
        #1;
        n_checks++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL drop_ready_post: got %b expected 0100", bus.req_ready);
        end
        sb.push_back(mk(2, 1'b0));
        wait_start(n);
        bus.req_valid = '0;
        n_checks++;
        if (n !== 1 || bus.dma_len !== sb[0].len || bus.dma_src !== sb[0].src) begin
            n_fail++; $display("FAIL zero_len_issue: got n=%0d len=%0d src=%h expected 1/%0d/%h",
                               n, bus.dma_len, bus.dma_src, sb[0].len, sb[0].src);
        end
        tick();
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (bus.cpl_valid !== 1'b1 || bus.cpl_id !== 2'(e.id) || bus.cpl_err !== e.err) begin
            n_fail++; $display("FAIL zero_len_cpl: got valid=%b id=%0d err=%b expected 1/%0d/%b",
                               bus.cpl_valid, bus.cpl_id, bus.cpl_err, e.id, e.err);
        end
        repeat (2) tick();
        n_checks++;
        if (bus.dma_src !== e.src || bus.dma_dst !== e.dst || bus.dma_len !== e.len) begin
            n_fail++; $display("FAIL hold_regs: got %h/%h/%0d expected %h/%h/%0d",
                               bus.dma_src, bus.dma_dst, bus.dma_len, e.src, e.dst, e.len);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_src   = '0;
        bus.req_dst   = '0;
        bus.req_len   = '0;
        bus.dma_done  = 1'b0;
        for (int i = 0; i < NR; i++) begin
            d_src[i] = '0;
            d_dst[i] = '0;
            d_len[i] = '0;
        end
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_tie();
        test_reset_mid_wait();
        test_stray_done();
        test_drop_zero_len();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
